// File: rtl/change_dispenser_if.sv
// Request/payout interface of the change dispenser. The master side issues
// change requests and refills; the slave side reports coins, status and
// the current inventory.
interface change_dispenser_if;
  logic       change_valid;
  logic [7:0] change_amount;
  logic       change_ready;
  logic       refill;
  logic       coin_valid;
  logic [1:0] coin_code;
  logic       done;
  logic       fault;
  logic [7:0] shortfall;
  logic [5:0] inv_1;
  logic [5:0] inv_5;
  logic [5:0] inv_10;
  logic [5:0] inv_50;

  modport master (
    output change_valid, change_amount, refill,
    input  change_ready, coin_valid, coin_code, done, fault, shortfall,
    input  inv_1, inv_5, inv_10, inv_50
  );

  modport slave (
    input  change_valid, change_amount, refill,
    output change_ready, coin_valid, coin_code, done, fault, shortfall,
    output inv_1, inv_5, inv_10, inv_50
  );
endinterface

// File: rtl/change_dispenser.sv
// Greedy coin-change dispenser: pays an accepted amount one coin per cycle,
// largest available denomination first, and aborts with a shortfall when
// the remaining inventory cannot complete the payout.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | ready for a request; refill is honoured here only
// DISPENSE | one coin per cycle while a coin fits; no coin -> FAULT
// DONE     | one-cycle done pulse, then IDLE
// FAULT    | one-cycle fault pulse, shortfall holds the unpaid amount
//
// Every output comes straight from a flop. The coin for a DISPENSE cycle is
// chosen one edge early from the next remaining/inventory values, so the
// registered coin_code_q is also the coin being paid in the current cycle.
module change_dispenser #(
  parameter int unsigned INIT_COUNT = 20
) (
  input logic          clk,
  input logic          reset,
  change_dispenser_if.slave dif
);

  localparam logic [5:0] INIT = 6'(INIT_COUNT);

  typedef enum logic [1:0] {IDLE, DISPENSE, DONE, FAULT} state_t;

  state_t     state_q, state_d;
  logic [7:0] remaining_q, remaining_d;
  logic [7:0] shortfall_q, shortfall_d;
  logic [5:0] inv1_q, inv1_d, inv5_q, inv5_d, inv10_q, inv10_d, inv50_q, inv50_d;
  logic       coin_valid_q, coin_valid_d;
  logic [1:0] coin_code_q, coin_code_d;
  logic       done_q, done_d, fault_q, fault_d, ready_q, ready_d;
  logic       accept;
  logic [2:0] sel;

  // {valid, code} of the largest coin that fits rem and is in stock
  function automatic logic [2:0] pick(input logic [7:0] rem, input logic [5:0] n1,
                                      input logic [5:0] n5, input logic [5:0] n10,
                                      input logic [5:0] n50);
    if (rem >= 8'd50 && n50 != 6'd0)      return 3'b111;
    else if (rem >= 8'd10 && n10 != 6'd0) return 3'b110;
    else if (rem >= 8'd5 && n5 != 6'd0)   return 3'b101;
    else if (rem >= 8'd1 && n1 != 6'd0)   return 3'b100;
    else                                  return 3'b000;
  endfunction

  function automatic logic [7:0] denom(input logic [1:0] code);
    case (code)
      2'd0:    return 8'd1;
      2'd1:    return 8'd5;
      2'd2:    return 8'd10;
      default: return 8'd50;
    endcase
  endfunction

  assign accept = (state_q == IDLE) && ready_q && dif.change_valid;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = (dif.change_amount == 8'd0) ? DONE : DISPENSE;
      end
      DISPENSE: begin
        if (!coin_valid_q)                              state_d = FAULT;
        else if (remaining_q == denom(coin_code_q))     state_d = DONE;
        else                                            state_d = DISPENSE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: remaining amount, inventories and shortfall
  always_comb begin
    remaining_d = remaining_q;
    shortfall_d = shortfall_q;
    inv1_d      = inv1_q;
    inv5_d      = inv5_q;
    inv10_d     = inv10_q;
    inv50_d     = inv50_q;
    case (state_q)
      IDLE: begin
        if (dif.refill) begin
          inv1_d  = INIT;
          inv5_d  = INIT;
          inv10_d = INIT;
          inv50_d = INIT;
        end
        if (accept) begin
          remaining_d = dif.change_amount;
          shortfall_d = 8'd0;
        end
      end
      DISPENSE: begin
        if (coin_valid_q) begin
          remaining_d = remaining_q - denom(coin_code_q);
          case (coin_code_q)
            2'd0:    inv1_d  = inv1_q - 6'd1;
            2'd1:    inv5_d  = inv5_q - 6'd1;
            2'd2:    inv10_d = inv10_q - 6'd1;
            default: inv50_d = inv50_q - 6'd1;
          endcase
        end else begin
          shortfall_d = remaining_q;
        end
      end
      default: ;
    endcase
  end

  // Output logic: registered outputs derived from the upcoming state
  always_comb begin
    sel          = pick(remaining_d, inv1_d, inv5_d, inv10_d, inv50_d);
    coin_valid_d = (state_d == DISPENSE) && sel[2];
    coin_code_d  = coin_valid_d ? sel[1:0] : 2'd0;
    done_d       = (state_d == DONE);
    fault_d      = (state_d == FAULT);
    ready_d      = (state_d == IDLE);
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      remaining_q  <= 8'd0;
      shortfall_q  <= 8'd0;
      inv1_q       <= INIT;
      inv5_q       <= INIT;
      inv10_q      <= INIT;
      inv50_q      <= INIT;
      coin_valid_q <= 1'b0;
      coin_code_q  <= 2'd0;
      done_q       <= 1'b0;
      fault_q      <= 1'b0;
      ready_q      <= 1'b1;
    end else begin
      remaining_q  <= remaining_d;
      shortfall_q  <= shortfall_d;
      inv1_q       <= inv1_d;
      inv5_q       <= inv5_d;
      inv10_q      <= inv10_d;
      inv50_q      <= inv50_d;
      coin_valid_q <= coin_valid_d;
      coin_code_q  <= coin_code_d;
      done_q       <= done_d;
      fault_q      <= fault_d;
      ready_q      <= ready_d;
    end
  end

  assign dif.change_ready = ready_q;
  assign dif.coin_valid   = coin_valid_q;
  assign dif.coin_code    = coin_code_q;
  assign dif.done         = done_q;
  assign dif.fault        = fault_q;
  assign dif.shortfall    = shortfall_q;
  assign dif.inv_1        = inv1_q;
  assign dif.inv_5        = inv5_q;
  assign dif.inv_10       = inv10_q;
  assign dif.inv_50       = inv50_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: one DUT with 20 coins per
// denomination, one with a single coin per denomination for the fault path.
module tb_change_dispenser;
  logic clk = 1'b0;
  logic reset;
  int   total  = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  change_dispenser_if a_if();
  change_dispenser_if b_if();

  change_dispenser #(.INIT_COUNT(20)) dut_a (.clk(clk), .reset(reset), .dif(a_if.slave));
  change_dispenser #(.INIT_COUNT(1))  dut_b (.clk(clk), .reset(reset), .dif(b_if.slave));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    a_if.change_valid = 1'b0; a_if.change_amount = 8'd0; a_if.refill = 1'b0;
    b_if.change_valid = 1'b0; b_if.change_amount = 8'd0; b_if.refill = 1'b0;
    tick(); tick();
    total++; if (a_if.change_ready !== 1'b1) $display("FAIL rst_ready got %b exp 1", a_if.change_ready); else passed++;
    total++; if ({a_if.coin_valid, a_if.coin_code, a_if.done, a_if.fault} !== 5'b0)
      $display("FAIL rst_outs got %b exp 00000", {a_if.coin_valid, a_if.coin_code, a_if.done, a_if.fault}); else passed++;
    total++; if (a_if.shortfall !== 8'd0) $display("FAIL rst_shortfall got %0d exp 0", a_if.shortfall); else passed++;
    @(negedge clk); reset = 1'b1;
    tick();
    total++; if (a_if.change_ready !== 1'b1 || a_if.coin_valid !== 1'b0)
      $display("FAIL rel_ready_valid got %b%b exp 10", a_if.change_ready, a_if.coin_valid); else passed++;
    total++; if ({a_if.inv_1, a_if.inv_5, a_if.inv_10, a_if.inv_50} !== {4{6'd20}})
      $display("FAIL rel_inv got %0d %0d %0d %0d exp 20 20 20 20", a_if.inv_1, a_if.inv_5, a_if.inv_10, a_if.inv_50); else passed++;
    total++; if ({b_if.inv_1, b_if.inv_5, b_if.inv_10, b_if.inv_50} !== {4{6'd1}})
      $display("FAIL rel_inv_b got %0d %0d %0d %0d exp 1 1 1 1", b_if.inv_1, b_if.inv_5, b_if.inv_10, b_if.inv_50); else passed++;
  endtask

  task automatic test_pay_87;
    logic [1:0] exp_code [7] = '{2'd3, 2'd2, 2'd2, 2'd2, 2'd1, 2'd0, 2'd0};
    a_if.change_valid = 1'b1; a_if.change_amount = 8'd87;
    tick();
    a_if.change_valid = 1'b0;
    for (int k = 0; k < 7; k++) begin
      total++; if (a_if.coin_valid !== 1'b1 || a_if.coin_code !== exp_code[k])
        $display("FAIL p87_coin cyc%0d got v=%b c=%0d exp v=1 c=%0d", k + 1, a_if.coin_valid, a_if.coin_code, exp_code[k]); else passed++;
      tick();
    end
    total++; if (a_if.done !== 1'b1 || a_if.coin_valid !== 1'b0)
      $display("FAIL p87_done got done=%b v=%b exp done=1 v=0", a_if.done, a_if.coin_valid); else passed++;
    total++; if ({a_if.inv_50, a_if.inv_10, a_if.inv_5, a_if.inv_1} !== {6'd19, 6'd17, 6'd19, 6'd18})
      $display("FAIL p87_inv got %0d %0d %0d %0d exp 19 17 19 18", a_if.inv_50, a_if.inv_10, a_if.inv_5, a_if.inv_1); else passed++;
    tick();
    total++; if (a_if.change_ready !== 1'b1 || a_if.done !== 1'b0)
      $display("FAIL p87_idle got ready=%b done=%b exp 1 0", a_if.change_ready, a_if.done); else passed++;
  endtask

  task automatic test_zero;
    a_if.change_valid = 1'b1; a_if.change_amount = 8'd0;
    tick();
    a_if.change_valid = 1'b0;
    total++; if ({a_if.coin_valid, a_if.done, a_if.change_ready} !== 3'b010)
      $display("FAIL zero_c1 got v/done/ready=%b exp 010", {a_if.coin_valid, a_if.done, a_if.change_ready}); else passed++;
    tick();
    total++; if ({a_if.done, a_if.change_ready} !== 2'b01)
      $display("FAIL zero_c2 got done/ready=%b exp 01", {a_if.done, a_if.change_ready}); else passed++;
  endtask

  task automatic test_fault;
    logic [1:0] exp_code [4] = '{2'd3, 2'd2, 2'd1, 2'd0};
    b_if.change_valid = 1'b1; b_if.change_amount = 8'd70;
    tick();
    b_if.change_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      total++; if (b_if.coin_valid !== 1'b1 || b_if.coin_code !== exp_code[k] || b_if.done !== 1'b0)
        $display("FAIL f70_coin cyc%0d got v=%b c=%0d d=%b exp v=1 c=%0d d=0", k + 1, b_if.coin_valid, b_if.coin_code, b_if.done, exp_code[k]); else passed++;
      tick();
    end
    total++; if ({b_if.coin_valid, b_if.fault, b_if.done} !== 3'b000)
      $display("FAIL f70_c5 got v/fault/done=%b exp 000", {b_if.coin_valid, b_if.fault, b_if.done}); else passed++;
    tick();
    total++; if ({b_if.fault, b_if.done, b_if.coin_valid} !== 3'b100 || b_if.shortfall !== 8'd4)
      $display("FAIL f70_c6 got fault/done/v=%b sf=%0d exp 100 sf=4", {b_if.fault, b_if.done, b_if.coin_valid}, b_if.shortfall); else passed++;
    total++; if ({b_if.inv_1, b_if.inv_5, b_if.inv_10, b_if.inv_50} !== 24'd0)
      $display("FAIL f70_inv got %0d %0d %0d %0d exp 0 0 0 0", b_if.inv_1, b_if.inv_5, b_if.inv_10, b_if.inv_50); else passed++;
    tick();
    total++; if (b_if.change_ready !== 1'b1 || b_if.fault !== 1'b0 || b_if.shortfall !== 8'd4)
      $display("FAIL f70_hold got ready=%b fault=%b sf=%0d exp 1 0 4", b_if.change_ready, b_if.fault, b_if.shortfall); else passed++;
  endtask

  task automatic test_refill_with_request;
    b_if.refill = 1'b1; b_if.change_valid = 1'b1; b_if.change_amount = 8'd6;
    tick();
    b_if.refill = 1'b0; b_if.change_valid = 1'b0;
    total++; if (b_if.coin_valid !== 1'b1 || b_if.coin_code !== 2'd1 || b_if.shortfall !== 8'd0)
      $display("FAIL rr_c1 got v=%b c=%0d sf=%0d exp v=1 c=1 sf=0", b_if.coin_valid, b_if.coin_code, b_if.shortfall); else passed++;
    tick();
    total++; if (b_if.coin_valid !== 1'b1 || b_if.coin_code !== 2'd0)
      $display("FAIL rr_c2 got v=%b c=%0d exp v=1 c=0", b_if.coin_valid, b_if.coin_code); else passed++;
    tick();
    total++; if (b_if.done !== 1'b1 || {b_if.inv_50, b_if.inv_10, b_if.inv_5, b_if.inv_1} !== {6'd1, 6'd1, 6'd0, 6'd0})
      $display("FAIL rr_done got done=%b inv %0d %0d %0d %0d exp 1 inv 1 1 0 0", b_if.done, b_if.inv_50, b_if.inv_10, b_if.inv_5, b_if.inv_1); else passed++;
  endtask

  task automatic test_back_to_back;
    // inventory entering: 50:19 10:17 5:19 1:18
    a_if.change_valid = 1'b1; a_if.change_amount = 8'd60;
    tick();
    a_if.refill = 1'b1;
    total++; if (a_if.coin_code !== 2'd3 || a_if.coin_valid !== 1'b1 || a_if.change_ready !== 1'b0)
      $display("FAIL b2b_c1 got v=%b c=%0d r=%b exp v=1 c=3 r=0", a_if.coin_valid, a_if.coin_code, a_if.change_ready); else passed++;
    tick();
    total++; if (a_if.coin_code !== 2'd2 || a_if.coin_valid !== 1'b1)
      $display("FAIL b2b_c2 got v=%b c=%0d exp v=1 c=2", a_if.coin_valid, a_if.coin_code); else passed++;
    tick();
    total++; if (a_if.done !== 1'b1 || a_if.inv_50 !== 6'd18 || a_if.inv_10 !== 6'd16)
      $display("FAIL b2b_done got done=%b inv50=%0d inv10=%0d exp 1 18 16", a_if.done, a_if.inv_50, a_if.inv_10); else passed++;
    tick();
    a_if.refill = 1'b0;
    total++; if (a_if.change_ready !== 1'b1 || a_if.coin_valid !== 1'b0)
      $display("FAIL b2b_idle got r=%b v=%b exp r=1 v=0", a_if.change_ready, a_if.coin_valid); else passed++;
    tick();
    a_if.change_valid = 1'b0;
    total++; if (a_if.coin_valid !== 1'b1 || a_if.coin_code !== 2'd3)
      $display("FAIL b2b_second got v=%b c=%0d exp v=1 c=3", a_if.coin_valid, a_if.coin_code); else passed++;
    tick(); tick(); tick();
    total++; if (a_if.change_ready !== 1'b1 || a_if.inv_50 !== 6'd17 || a_if.inv_10 !== 6'd15)
      $display("FAIL b2b_end got r=%b inv50=%0d inv10=%0d exp 1 17 15", a_if.change_ready, a_if.inv_50, a_if.inv_10); else passed++;
  endtask

  task automatic test_reset_mid;
    a_if.change_valid = 1'b1; a_if.change_amount = 8'd255;
    tick();
    a_if.change_valid = 1'b0;
    tick(); tick();
    total++; if (a_if.coin_valid !== 1'b1 || a_if.inv_50 !== 6'd15)
      $display("FAIL mid_pre got v=%b inv50=%0d exp v=1 inv50=15", a_if.coin_valid, a_if.inv_50); else passed++;
    reset = 1'b0;
    #1;
    total++; if ({a_if.change_ready, a_if.coin_valid, a_if.coin_code, a_if.done, a_if.fault} !== 6'b100000 || a_if.shortfall !== 8'd0)
      $display("FAIL mid_outs got %b sf=%0d exp 100000 sf=0", {a_if.change_ready, a_if.coin_valid, a_if.coin_code, a_if.done, a_if.fault}, a_if.shortfall); else passed++;
    total++; if ({a_if.inv_1, a_if.inv_5, a_if.inv_10, a_if.inv_50} !== {4{6'd20}})
      $display("FAIL mid_inv got %0d %0d %0d %0d exp 20 20 20 20", a_if.inv_1, a_if.inv_5, a_if.inv_10, a_if.inv_50); else passed++;
    @(negedge clk); reset = 1'b1;
    tick(); tick();
    total++; if (a_if.change_ready !== 1'b1 || a_if.coin_valid !== 1'b0)
      $display("FAIL mid_after got r=%b v=%b exp r=1 v=0", a_if.change_ready, a_if.coin_valid); else passed++;
  endtask

  initial begin
    test_reset();
    test_pay_87();
    test_zero();
    test_fault();
    test_refill_with_request();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 Parameter INIT_COUNT, default 20: coins per denomination loaded at reset and on refill; legal range 0-63.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 change_valid  input  1  change request present.
REQ-005 change_amount  input  8  change owed to the customer, in currency units.
REQ-006 change_ready  output  1  block can accept a request.
REQ-007 refill  input  1  reload all inventories to INIT_COUNT.
REQ-008 coin_valid  output  1  one coin ejected this cycle.
REQ-009 coin_code  output  2  ejected coin: 0=1, 1=5, 2=10, 3=50.
REQ-010 done  output  1  one-cycle pulse: request fully paid.
REQ-011 fault  output  1  one-cycle pulse: request aborted, inventory insufficient.
REQ-012 shortfall  output  8  amount left unpaid by the last faulted request.
REQ-013 inv_1, inv_5, inv_10, inv_50  output  6 each  current coin counts.

Function
REQ-014 States SHALL be IDLE, DISPENSE, DONE and FAULT; all outputs SHALL be registered.
REQ-015 change_ready SHALL be 1 only in IDLE.
REQ-016 A request SHALL be accepted on a clk edge with change_valid=1 and change_ready=1; change_amount is latched into an 8-bit remaining register and shortfall is cleared to 0.
REQ-017 On acceptance with change_amount=0, next state SHALL be DONE; otherwise DISPENSE.
REQ-018 Each DISPENSE cycle SHALL select the largest denomination d with d<=remaining and a nonzero inventory, in priority 50, 10, 5, 1.
REQ-019 When a coin is selected: coin_valid=1 and coin_code=its code in that same cycle; on the closing edge, remaining decrements by d and that inventory decrements by 1.
REQ-020 Exactly one coin SHALL be ejected per DISPENSE cycle; coin_valid SHALL be 0 in all other states.
REQ-021 When remaining reaches 0 after a decrement, next state SHALL be DONE.
REQ-022 When remaining>0 and no coin qualifies: coin_valid=0 that cycle, next state FAULT, shortfall<=remaining.
REQ-023 DONE and FAULT SHALL each last exactly one cycle, assert done or fault respectively, then return to IDLE.
REQ-024 shortfall SHALL hold its value until the next accepted request.
REQ-025 Latency: for an accepted request needing N coins, coin_valid is high on cycles 1..N after the accept edge, and done is high on cycle N+1.
REQ-026 refill SHALL take effect only in IDLE.
REQ-027 refill and change_valid high together in IDLE: both take effect; the request uses the refilled counts from its first DISPENSE cycle.
REQ-028 refill SHALL be ignored in DISPENSE, DONE and FAULT.
REQ-029 change_valid in non-IDLE states SHALL be ignored and not queued.
REQ-030 Inventories SHALL never wrap below 0; REQ-018 guarantees this.

Reset
REQ-031 While reset=0: state=IDLE, change_ready=1, coin_valid=0, coin_code=0, done=0, fault=0, shortfall=0, remaining=0, all inv_*=INIT_COUNT.
REQ-032 Reset asserted mid-DISPENSE SHALL abort immediately; the partial payout is not recorded and inventories return to INIT_COUNT.

Verification
REQ-033 Reset release -> change_ready=1, coin_valid=0, inv_1=inv_5=inv_10=inv_50=20.
REQ-034 Accept 87 with INIT_COUNT=20 -> coin_code 3,2,2,2,1,0,0 on cycles 1-7; done on cycle 8; inv_50=19, inv_10=17, inv_5=19, inv_1=18.
REQ-035 Accept 0 -> no coin_valid; done on cycle 1; change_ready=1 on cycle 2.
REQ-036 INIT_COUNT=1, accept 70 -> coins 3,2,1,0 on cycles 1-4; fault on cycle 6; shortfall=4; inventories all 0; done never asserted.
REQ-037 Accept 255, assert reset on cycle 3 -> outputs immediately at REQ-031 values; inventories=INIT_COUNT.
REQ-038 change_valid and refill held high during a 60 payout -> refill ignored, second request accepted only after the return to IDLE.
